sum_pow_seq: RTL and testbench
==============================

Name: sum_pow_seq

Overview:
- Sequential, parametrised successor to the combinational sum-of-squares block.
- Computes S = sum of i^k for i = 0..n, with k in {0,1,2,3} selected per operation.
- Evaluates one term per clock, using a start/busy/done handshake and overflow detection.
- Sits in the arithmetic utility library as a reusable series accumulator, so wide n no longer requires an unrolled combinational loop.

Parameters:
- WIDTH, 32: width of the accumulator and the result.
- N_WIDTH, 16: width of the operand n and the internal index i.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled on a rising edge.
- n  input  N_WIDTH  upper bound, inclusive; captured when start is accepted.
- mode  input  2  exponent k: 0 gives i, 1 gives i^2, 2 gives i^3, 3 gives i^0 (count).
- busy  output  1  high while accumulating.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  final sum; holds until the next completion.
- overflow  output  1  set if the true sum exceeds WIDTH bits; valid with done.

Behaviour:
- Reset, asynchronous and immediate: state=IDLE, busy=0, done=0, result=0, overflow=0, i=0, acc=0.
- Reset asserted mid-operation aborts the operation. No done is produced.
- States:
  - IDLE: on start=1, capture n_q=n and mode_q=mode, clear acc, i and ovf, then go to ACCUM.
  - ACCUM: each edge, acc <= acc + term(i). If i == n_q, go to DONE; otherwise i <= i+1.
  - DONE: done=1 for exactly one cycle; result <= final acc and overflow <= ovf are loaded on the ACCUM->DONE edge.
    - If start=1 in DONE, the next operation is accepted, as from IDLE, and the FSM goes directly to ACCUM (back-to-back).
    - Otherwise the FSM goes to IDLE.
- busy = (state == ACCUM). start is ignored while busy.
- Latency: with start sampled on edge E, ACCUM covers edges E+1..E+n+1, done is high in the cycle following edge E+n+1, and busy is high for exactly n+1 cycles.
- term(i):
  - Computed at 3*N_WIDTH bits: i, i*i, or i*i*i by mode; mode 3 gives 1.
  - Zero-extended or checked against WIDTH.
  - The term for i=0 is 0 for modes 0-2 and 1 for mode 3.
- Overflow (ovf, sticky within an operation): set if term(i) has any bit set at or above WIDTH, or if the WIDTH+1-bit sum acc + term carries out.
- Without saturation, acc wraps modulo 2^WIDTH.
- n = 0 is legal: single ACCUM cycle.
- n = 2^N_WIDTH-1: i must not wrap before the i == n_q compare, so the compare is made before the increment.
- result and overflow hold their values through IDLE and during the next ACCUM, until the next DONE.
- No combinational path from start, n or mode to any output.

Optional Feature:
- SUM_POW_SAT_EN defined: once ovf is set, acc is forced to all-ones and held; result = {WIDTH{1'b1}} and overflow=1 at done.
- Not defined: acc wraps modulo 2^WIDTH; overflow flag only.

Test Plan:
- mode=1, n=5, start one cycle -> busy high for 6 cycles, done one cycle later, result=55, overflow=0. This is the regression against the original block.
- mode=0, n=100 -> result=5050. mode=2, n=10 -> result=3025. mode=3, n=0 -> result=1, done 1 cycle after busy.
- mode=1, n=0 -> result=0. Then back-to-back: start held high in the DONE cycle with mode=0, n=3 -> second done result=6 with no IDLE cycle; start pulses while busy are ignored.
- WIDTH=32, mode=2, n=400 (true sum 6432040000):
  - Without the macro -> overflow=1, result=2137072704.
  - With SUM_POW_SAT_EN -> overflow=1, result=0xFFFFFFFF.
- rst pulsed at the 3rd ACCUM cycle of a mode=1, n=20 run -> busy=0, done never asserts, result=0. A subsequent mode=1, n=5 run gives 55.

Source files
------------

// File: rtl/sum_pow_seq_if.sv
`default_nettype none
// ============================================================================
//  Module  : sum_pow_seq_if
//  Brief   : start/busy/done handshake and result bus for sum_pow_seq.
//  Rev     : 1.0  initial release
// ============================================================================
interface sum_pow_seq_if #(
    parameter int WIDTH   = 32,
    parameter int N_WIDTH = 16
);
    logic               start;
    logic [N_WIDTH-1:0] n;
    logic [1:0]         mode;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               overflow;

    modport master (
        output start, n, mode,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, n, mode,
        output busy, done, result, overflow
    );
endinterface
`default_nettype wire

// File: rtl/sum_pow_seq.sv
`default_nettype none
// ============================================================================
//  Module  : sum_pow_seq
//  Brief   : sequential series accumulator, S = sum(i^k, i=0..n), one term per
//            clock. Define SUM_POW_SAT_EN to saturate the sum on overflow.
//  Rev     : 1.0  initial release
// ============================================================================
module sum_pow_seq #(
    parameter int WIDTH   = 32,
    parameter int N_WIDTH = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    sum_pow_seq_if.slave  bus
);
    localparam int         c_TERM_W = 3 * N_WIDTH;
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCUM  = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]          r_state;
    logic [N_WIDTH-1:0]  r_n;
    logic [N_WIDTH-1:0]  r_i;
    logic [1:0]          r_mode;
    logic [WIDTH-1:0]    r_acc;
    logic                r_ovf;
    logic                r_busy;
    logic                r_done;
    logic [WIDTH-1:0]    r_result;
    logic                r_overflow;

    logic [2*N_WIDTH-1:0] w_i2;
    logic [2*N_WIDTH-1:0] w_sq;
    logic [c_TERM_W-1:0]  w_i3;
    logic [c_TERM_W-1:0]  w_cube;
    logic [c_TERM_W-1:0]  w_term3;
    logic [WIDTH-1:0]     w_term;
    logic                 w_term_hi;
    logic [WIDTH:0]       w_sum;
    logic                 w_ovf_next;
    logic [WIDTH-1:0]     w_acc_next;

    // Operands are widened before multiplying so no product is truncated.
    assign w_i2   = {{N_WIDTH{1'b0}}, r_i};
    assign w_i3   = {{(2*N_WIDTH){1'b0}}, r_i};
    assign w_sq   = w_i2 * w_i2;
    assign w_cube = {{N_WIDTH{1'b0}}, w_sq} * w_i3;

    always_comb begin
        w_term3 = '0;
        case (r_mode)
            2'd0:    w_term3 = w_i3;
            2'd1:    w_term3 = {{N_WIDTH{1'b0}}, w_sq};
            2'd2:    w_term3 = w_cube;
            default: w_term3 = {{(c_TERM_W-1){1'b0}}, 1'b1};
        endcase
    end

    generate
        if (c_TERM_W > WIDTH) begin : g_term_trunc
            assign w_term    = w_term3[WIDTH-1:0];
            assign w_term_hi = |w_term3[c_TERM_W-1:WIDTH];
        end else if (c_TERM_W == WIDTH) begin : g_term_exact
            assign w_term    = w_term3;
            assign w_term_hi = 1'b0;
        end else begin : g_term_ext
            assign w_term    = {{(WIDTH-c_TERM_W){1'b0}}, w_term3};
            assign w_term_hi = 1'b0;
        end
    endgenerate

    assign w_sum      = {1'b0, r_acc} + {1'b0, w_term};
    assign w_ovf_next = r_ovf | w_term_hi | w_sum[WIDTH];

`ifdef SUM_POW_SAT_EN
    // Sticky overflow pins the accumulator at all-ones for the rest of the run.
    assign w_acc_next = w_ovf_next ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_acc_next = w_sum[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_n        <= '0;
            r_i        <= '0;
            r_mode     <= 2'd0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (bus.start) begin
                        r_n     <= bus.n;
                        r_mode  <= bus.mode;
                        r_i     <= '0;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= c_ACCUM;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_ovf <= w_ovf_next;
                    // Compare before incrementing so n = all-ones terminates.
                    if (r_i == r_n) begin
                        r_result   <= w_acc_next;
                        r_overflow <= w_ovf_next;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= c_DONE;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_sum_pow_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sum_pow_seq
//  Brief   : scoreboard bench for sum_pow_seq against an arithmetic model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sum_pow_seq;
    localparam int WIDTH   = 32;
    localparam int N_WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   fails;
    exp_t sb_q[$];

    sum_pow_seq_if #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) bus ();

    sum_pow_seq #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain summation of i^k in wide arithmetic.
    function automatic exp_t model(input int unsigned nn, input int unsigned md);
        logic [127:0] s;
        logic [127:0] iv;
        logic [127:0] t;
        exp_t         e;
        s = '0;
        for (longint unsigned i = 0; i <= longint'(nn); i++) begin
            iv = 128'(i);
            case (md)
                0:       t = iv;
                1:       t = iv * iv;
                2:       t = iv * iv * iv;
                default: t = 128'd1;
            endcase
            s = s + t;
        end
        e.ovf = ((s >> WIDTH) != 0);
`ifdef SUM_POW_SAT_EN
        e.res = e.ovf ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
        e.res = s[WIDTH-1:0];
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            exp_t e;
            vectors++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: result=%0d overflow=%0b, no operation outstanding",
                         bus.result, bus.overflow);
            end else begin
                e = sb_q.pop_front();
                if (bus.result !== e.res || bus.overflow !== e.ovf) begin
                    fails++;
                    $display("FAIL result_check: got result=%0d ovf=%0b, expected result=%0d ovf=%0b",
                             bus.result, bus.overflow, e.res, e.ovf);
                end
            end
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Issue one operation, then check busy length and the single-cycle done.
    task automatic run_op(input int unsigned nn, input int unsigned md);
        int unsigned busy_cnt;
        bit          got;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.n     = N_WIDTH'(nn);
        bus.mode  = 2'(md);
        sb_q.push_back(model(nn, md));
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_cnt = 0;
        got      = 1'b0;
        for (int c = 0; c < int'(nn) + 8 && !got; c++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        check("done_seen", WIDTH'(got), 1);
        check("busy_cycles", WIDTH'(busy_cnt), WIDTH'(nn + 1));
        @(negedge clk);
        check("done_one_cycle", WIDTH'(bus.done), 0);
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        vectors   = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.n     = '0;
        bus.mode  = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", WIDTH'(bus.busy), 0);
        check("reset_done", WIDTH'(bus.done), 0);
        check("reset_result", bus.result, 0);
        check("reset_overflow", WIDTH'(bus.overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(5, 1);
        check("hold_result_55", bus.result, 55);
        run_op(100, 0);
        run_op(10, 2);
        run_op(0, 3);
        run_op(400, 2);
        check("ovf_400_cubes", WIDTH'(bus.overflow), 1);

        // Back-to-back: second start accepted in the DONE cycle.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.n = 16'd0; bus.mode = 2'd1;
        sb_q.push_back(model(0, 1));
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(10, got);
        check("b2b_first_done", WIDTH'(got), 1);
        bus.start = 1'b1; bus.n = 16'd3; bus.mode = 2'd0;
        sb_q.push_back(model(3, 0));
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b_no_idle", WIDTH'(bus.busy), 1);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.n = 16'd7; bus.mode = 2'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(12, got);
        check("b2b_second_done", WIDTH'(got), 1);
        check("b2b_result_6", bus.result, 6);
        repeat (12) @(negedge clk);
        check("ignored_start_idle", WIDTH'(bus.busy), 0);

        // Abort in the third ACCUM cycle; no done may follow.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.n = 16'd20; bus.mode = 2'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_busy", WIDTH'(bus.busy), 0);
        check("abort_done", WIDTH'(bus.done), 0);
        check("abort_result", bus.result, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        run_op(5, 1);

        for (int k = 0; k < 16; k++) begin
            int unsigned rn;
            int unsigned rm;
            rm = $urandom_range(0, 3);
            rn = (k % 4 == 3) ? $urandom_range(250, 400) : $urandom_range(0, 120);
            run_op(rn, rm);
        end

        run_op(32'h0000_FFFF, 3);
        check("max_n_count", bus.result, 65536);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", WIDTH'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
`default_nettype wire
